// File: rtl/q_pulse_meter_if.sv
// rtl/q_pulse_meter_if.sv - control and result bundle of the charge pulse meter
//
// Purpose: groups the measurement controls and the published burst results.
// Signals:
//    enable       controller -> meter  measurement enable, low aborts a burst
//    start        controller -> meter  arm request (level)
//    q_serialized source -> meter      raw pulse train, asynchronous to clk
//    q_measured   meter -> controller  charge of the last completed burst
//    ready        meter -> controller  one-cycle strobe, results valid with it
//    pulse_count  meter -> controller  pulses in the last completed burst
//    overflow     meter -> controller  last completed burst saturated
interface q_pulse_meter_if #(
   parameter int BUS_WIDTH = 10
);
   logic                 enable;
   logic                 start;
   logic                 q_serialized;
   logic [BUS_WIDTH-1:0] q_measured;
   logic                 ready;
   logic [BUS_WIDTH-1:0] pulse_count;
   logic                 overflow;

   modport master (
      output enable, start, q_serialized,
      input  q_measured, ready, pulse_count, overflow
   );

   modport slave (
      input  enable, start, q_serialized,
      output q_measured, ready, pulse_count, overflow
   );
endinterface

// File: rtl/q_pulse_meter.sv
// rtl/q_pulse_meter.sv - converts a serialized charge pulse train into a charge word
//
// Purpose: counts rising edges of q_serialized, weights each by Q_PER_PULSE and
// publishes the burst total once the line has been idle for 2**WTD_BUS_WIDTH-1
// cycles.
// Ports:
//    clk  system clock, rising edge
//    rst  asynchronous active-low reset
//    bus  q_pulse_meter_if.slave (controls in, burst results out)
module q_pulse_meter #(
   parameter int BUS_WIDTH     = 10,
   parameter int WTD_BUS_WIDTH = 3,
   parameter int Q_PER_PULSE   = 3
) (
   input logic            clk,
   input logic            rst,
   q_pulse_meter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNT, S_DONE} state_t;

   localparam logic [BUS_WIDTH-1:0]     ACC_MAX  = '1;
   localparam logic [BUS_WIDTH:0]       Q_EXT    = (BUS_WIDTH+1)'(Q_PER_PULSE);
   localparam logic [WTD_BUS_WIDTH-1:0] WDT_LAST = WTD_BUS_WIDTH'(2**WTD_BUS_WIDTH - 2);

   state_t                 state_q, state_d;
   logic                   s1_q, s2_q, s3_q;
   logic [BUS_WIDTH-1:0]   acc_q, acc_d;
   logic [BUS_WIDTH-1:0]   pcnt_q, pcnt_d;
   logic [WTD_BUS_WIDTH-1:0] wdt_q, wdt_d;
   logic                   ovf_q, ovf_d;
   logic [BUS_WIDTH-1:0]   qmeas_q, qmeas_d;
   logic [BUS_WIDTH-1:0]   pcount_q, pcount_d;
   logic                   ovfout_q, ovfout_d;
   logic                   rise;
   logic                   expire;
   logic                   ready_w;
   logic [BUS_WIDTH:0]     sum_w;

   assign rise   = s2_q & ~s3_q;
   // The watchdog only counts low cycles, so a rising edge can never coincide
   // with expiry.
   assign expire = (wdt_q == WDT_LAST) && !s2_q;

   // Extra top bit flags saturation; the base is zero for the first pulse.
   function automatic logic [BUS_WIDTH:0] sat_add(input logic [BUS_WIDTH-1:0] a);
      logic [BUS_WIDTH:0] s;
      s = {1'b0, a} + Q_EXT;
      if (s[BUS_WIDTH]) return {1'b1, ACC_MAX};
      return s;
   endfunction

   assign sum_w = sat_add((state_q == S_COUNT) ? acc_q : '0);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; enable low overrides everything, including DONE.
   always_comb begin
      state_d = state_q;
      if (!bus.enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ARMED;
            S_ARMED: if (rise) state_d = S_COUNT;
            S_COUNT: if (expire) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_ARMED : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      ready_w = (state_q == S_DONE);
   end

   // Datapath next state
   always_comb begin
      acc_d    = acc_q;
      pcnt_d   = pcnt_q;
      wdt_d    = wdt_q;
      ovf_d    = ovf_q;
      qmeas_d  = qmeas_q;
      pcount_d = pcount_q;
      ovfout_d = ovfout_q;
      if (!bus.enable) begin
         acc_d  = '0;
         pcnt_d = '0;
         wdt_d  = '0;
         ovf_d  = 1'b0;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (rise) begin
                  acc_d  = sum_w[BUS_WIDTH-1:0];
                  ovf_d  = sum_w[BUS_WIDTH];
                  pcnt_d = BUS_WIDTH'(1);
                  wdt_d  = '0;
               end
            end
            S_COUNT: begin
               if (rise) begin
                  acc_d  = sum_w[BUS_WIDTH-1:0];
                  ovf_d  = ovf_q | sum_w[BUS_WIDTH];
                  pcnt_d = (pcnt_q == ACC_MAX) ? ACC_MAX : pcnt_q + 1'b1;
               end
               if (s2_q) wdt_d = '0;
               else if (wdt_q != WDT_LAST) wdt_d = wdt_q + 1'b1;
               // Results are loaded on entry to DONE so they are valid
               // in the same cycle as the ready strobe.
               if (expire) begin
                  qmeas_d  = acc_q;
                  pcount_d = pcnt_q;
                  ovfout_d = ovf_q;
               end
            end
            S_DONE: begin
               acc_d  = '0;
               pcnt_d = '0;
               wdt_d  = '0;
               ovf_d  = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         acc_q    <= '0;
         pcnt_q   <= '0;
         wdt_q    <= '0;
         ovf_q    <= 1'b0;
         qmeas_q  <= '0;
         pcount_q <= '0;
         ovfout_q <= 1'b0;
      end else begin
         s1_q     <= bus.q_serialized;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         acc_q    <= acc_d;
         pcnt_q   <= pcnt_d;
         wdt_q    <= wdt_d;
         ovf_q    <= ovf_d;
         qmeas_q  <= qmeas_d;
         pcount_q <= pcount_d;
         ovfout_q <= ovfout_d;
      end
   end

   assign bus.q_measured  = qmeas_q;
   assign bus.pulse_count = pcount_q;
   assign bus.overflow    = ovfout_q;
   assign bus.ready       = ready_w;
endmodule

// File: tb/tb_q_pulse_meter.sv
// tb/tb_q_pulse_meter.sv - directed scoreboard bench for q_pulse_meter
module tb_q_pulse_meter;
   typedef struct {
      logic [9:0] q;
      logic [9:0] p;
      logic       o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic prev_ready = 1'b0;
   exp_t sb[$];

   q_pulse_meter_if #(.BUS_WIDTH(10)) bus ();

   q_pulse_meter #(.BUS_WIDTH(10), .WTD_BUS_WIDTH(3), .Q_PER_PULSE(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int q, input int p, input logic o);
      exp_t e;
      e.q = 10'(q);
      e.p = 10'(p);
      e.o = o;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         bus.q_serialized = 1'b1;
         repeat (hi) @(negedge clk);
         bus.q_serialized = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest expected burst.
   always @(negedge clk) begin
      if (rst && bus.ready) begin
         chk("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
         chk("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q_measured", {22'd0, bus.q_measured}, {22'd0, e.q});
            chk("pulse_count", {22'd0, bus.pulse_count}, {22'd0, e.p});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
         end
      end
      prev_ready = bus.ready;
   end

   initial begin
      bus.enable       = 1'b0;
      bus.start        = 1'b0;
      bus.q_serialized = 1'b0;
      idle(3);
      chk("rst_q_measured", {22'd0, bus.q_measured}, 32'd0);
      chk("rst_pulse_count", {22'd0, bus.pulse_count}, 32'd0);
      chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      chk("rst_ready", {31'd0, bus.ready}, 32'd0);
      rst = 1'b1;
      idle(2);

      // Basic 10-pulse burst
      bus.start  = 1'b1;
      bus.enable = 1'b1;
      idle(3);
      push(30, 10, 1'b0);
      pulses(10, 3, 3);
      idle(20);

      // Saturating burst followed by a clean one
      push(1023, 400, 1'b1);
      pulses(400, 3, 3);
      idle(20);
      push(6, 2, 1'b0);
      pulses(2, 3, 3);
      idle(20);

      // Watchdog boundary: 6 low cycles keep the burst, 8 split it
      push(12, 4, 1'b0);
      pulses(4, 3, 6);
      idle(20);
      push(9, 3, 1'b0);
      push(6, 2, 1'b0);
      pulses(3, 3, 3);
      idle(5);
      pulses(2, 3, 3);
      idle(20);

      // Abort via enable, then re-enable
      pulses(5, 3, 3);
      bus.enable = 1'b0;
      idle(20);
      chk("abort_keeps_q", {22'd0, bus.q_measured}, 32'd6);
      chk("abort_keeps_pcnt", {22'd0, bus.pulse_count}, 32'd2);
      bus.enable = 1'b1;
      idle(2);
      push(12, 4, 1'b0);
      pulses(4, 3, 3);
      idle(20);

      // Asynchronous reset mid-burst
      pulses(3, 3, 3);
      bus.q_serialized = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_q_measured", {22'd0, bus.q_measured}, 32'd0);
      chk("async_pulse_count", {22'd0, bus.pulse_count}, 32'd0);
      chk("async_overflow", {31'd0, bus.overflow}, 32'd0);
      chk("async_ready", {31'd0, bus.ready}, 32'd0);
      bus.q_serialized = 1'b0;
      bus.start        = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      pulses(5, 3, 3);
      idle(20);
      chk("no_rearm_q", {22'd0, bus.q_measured}, 32'd0);

      // Long armed wait with no pulses
      bus.start = 1'b1;
      idle(5000);
      chk("armed_wait_ready", {31'd0, bus.ready}, 32'd0);
      chk("armed_wait_q", {22'd0, bus.q_measured}, 32'd0);

      // Pulse whose edge lands while still disabled is ignored
      bus.enable = 1'b0;
      idle(3);
      bus.q_serialized = 1'b1;
      idle(3);
      bus.q_serialized = 1'b0;
      bus.enable       = 1'b1;
      idle(10);
      push(6, 2, 1'b0);
      pulses(2, 3, 3);
      idle(20);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
